// File: rtl/vga_pkg.sv
// Shared VGA definitions: mode encodings and the mode-change controller's state type.
package vga_pkg;

    localparam logic VGA_MODE_640X480  = 1'b0;
    localparam logic VGA_MODE_1440X900 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FE,
        SETTLE,
        MUTE,
        DONE
    } vga_mode_ctrl_state_t;

endpackage

// File: rtl/vga_mode_ctrl.sv
// Run-time video mode change sequencer: waits for frame end, resets the sync generator, mutes, acks.
// Optional mute phase is compiled in with `define VGA_MODE_CTRL_MUTE_EN.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int DEFAULT_MODE  = 0,
    parameter int SETTLE_CYCLES = 16,
    parameter int MUTE_FRAMES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req,
    input  logic       i_mode,
    output logic       o_ack,
    output logic       o_busy,
    input  logic       i_hmax,
    input  logic       i_vmax,
    output logic       o_mode,
    output logic       o_sync_reset,
    output logic       o_mute,
    output logic [7:0] o_frame_count
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES);
    localparam int MUTE_W   = $clog2(MUTE_FRAMES);
    localparam int MAX_W    = (SETTLE_W > MUTE_W) ? SETTLE_W : MUTE_W;
    localparam int CNT_W    = (MAX_W > 1) ? MAX_W : 1;

    localparam logic RESET_MODE = (DEFAULT_MODE == 0) ? VGA_MODE_640X480 : VGA_MODE_1440X900;

    vga_mode_ctrl_state_t state;
    logic                 target;
    logic [CNT_W-1:0]     cnt;
    logic                 fe;

    assign fe = i_hmax & i_vmax;

`ifndef VGA_MODE_CTRL_MUTE_EN
    assign o_mute = 1'b0;
`endif

    // The frame counter update sits ahead of the FSM so that a mode switch clears it with priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            target        <= RESET_MODE;
            cnt           <= '0;
            o_mode        <= RESET_MODE;
            o_ack         <= 1'b0;
            o_busy        <= 1'b0;
            o_sync_reset  <= 1'b0;
            o_frame_count <= 8'd0;
`ifdef VGA_MODE_CTRL_MUTE_EN
            o_mute        <= 1'b0;
`endif
        end else begin
            if (fe && !o_sync_reset) begin
                o_frame_count <= o_frame_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (i_req) begin
                        target <= i_mode;
                        o_busy <= 1'b1;
                        state  <= (i_mode == o_mode) ? DONE : WAIT_FE;
                    end
                end

                WAIT_FE: begin
                    if (fe) begin
                        o_mode        <= target;
                        o_sync_reset  <= 1'b1;
                        o_frame_count <= 8'd0;
                        cnt           <= CNT_W'(SETTLE_CYCLES - 1);
`ifdef VGA_MODE_CTRL_MUTE_EN
                        o_mute        <= 1'b1;
`endif
                        state         <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (cnt == '0) begin
                        o_sync_reset <= 1'b0;
`ifdef VGA_MODE_CTRL_MUTE_EN
                        if (MUTE_FRAMES == 0) begin
                            o_mute <= 1'b0;
                            state  <= DONE;
                        end else begin
                            cnt   <= CNT_W'(MUTE_FRAMES - 1);
                            state <= MUTE;
                        end
`else
                        state <= DONE;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

`ifdef VGA_MODE_CTRL_MUTE_EN
                // The last mute frame releases video and completes the handshake on the same edge.
                MUTE: begin
                    if (fe) begin
                        if (cnt == '0) begin
                            o_mute <= 1'b0;
                            o_ack  <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
`endif

                DONE: begin
                    if (!o_ack) begin
                        o_ack <= 1'b1;
                    end else if (!i_req) begin
                        o_ack  <= 1'b0;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
